// File: rtl/floor_tracker_if.sv
// Request/status bundle between the scheduler side (master) and the floor tracker (slave).
interface floor_tracker_if #(
  parameter int unsigned W = 4
);
  logic         habilitar;
  logic         go;
  logic [W-1:0] target;
  logic [W-1:0] S;
  logic         C;
  logic         moving;
  logic         arrived;
  logic         err;

  modport master (
    output habilitar, go, target,
    input  S, C, moving, arrived, err
  );

  modport slave (
    input  habilitar, go, target,
    output S, C, moving, arrived, err
  );
endinterface

// File: rtl/floor_tracker.sv
// Elevator floor tracker: steps one floor every TRAVEL enabled cycles toward a
// latched target, pulses arrived on reaching it and err on an out-of-building request.
module floor_tracker #(
  parameter int unsigned W      = 4,
  parameter int unsigned FLOORS = 10,
  parameter int unsigned TRAVEL = 4
) (
  input  logic           clk,
  input  logic           clear,
  floor_tracker_if.slave bus
);

  localparam int unsigned TW = (TRAVEL > 1) ? $clog2(TRAVEL) : 1;
  localparam int unsigned WX = W + 1;
  localparam logic [WX-1:0] FLOORS_X   = WX'(FLOORS);
  localparam logic [W-1:0]  TOP_FLOOR  = W'(FLOORS - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TRAVEL - 1);

  typedef enum logic {IDLE, MOVE} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  s_q, s_d;
  logic          c_q, c_d;
  logic          moving_q, moving_d;
  logic          arrived_q, arrived_d;
  logic          err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [W-1:0]  tgt_q, tgt_d;

  logic [W-1:0]  s_next_c;
  logic          step_ok_c;

  // Neighbouring floor in the current direction; the building edge blocks the step.
  always_comb begin
    s_next_c  = c_q ? (s_q - W'(1)) : (s_q + W'(1));
    step_ok_c = c_q ? (s_q != '0) : (s_q != TOP_FLOOR);
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    c_d       = c_q;
    moving_d  = moving_q;
    arrived_d = 1'b0;
    err_d     = 1'b0;
    timer_d   = timer_q;
    tgt_d     = tgt_q;

    case (state_q)
      IDLE: begin
        if (bus.habilitar && bus.go) begin
          if ({1'b0, bus.target} >= FLOORS_X) begin
            err_d = 1'b1;
          end else if (bus.target == s_q) begin
            arrived_d = 1'b1;
          end else begin
            tgt_d    = bus.target;
            c_d      = (bus.target < s_q);
            timer_d  = '0;
            state_d  = MOVE;
            moving_d = 1'b1;
          end
        end
      end
      MOVE: begin
        if (bus.habilitar) begin
          if (timer_q != TIMER_LAST) begin
            timer_d = timer_q + TW'(1);
          end else begin
            timer_d = '0;
            if (step_ok_c) begin
              s_d = s_next_c;
              // Arrival is decided on the same edge that lands on the target.
              if (s_next_c == tgt_q) begin
                state_d   = IDLE;
                moving_d  = 1'b0;
                arrived_d = 1'b1;
              end
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q   <= IDLE;
      s_q       <= '0;
      c_q       <= 1'b0;
      moving_q  <= 1'b0;
      arrived_q <= 1'b0;
      err_q     <= 1'b0;
      timer_q   <= '0;
      tgt_q     <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      c_q       <= c_d;
      moving_q  <= moving_d;
      arrived_q <= arrived_d;
      err_q     <= err_d;
      timer_q   <= timer_d;
      tgt_q     <= tgt_d;
    end
  end

  assign bus.S       = s_q;
  assign bus.C       = c_q;
  assign bus.moving  = moving_q;
  assign bus.arrived = arrived_q;
  assign bus.err     = err_q;

endmodule
